spi_reg_initiator: RTL and testbench
====================================

Name: spi_reg_initiator

Overview:
- SPI mode-0 slave front-end that turns serial frames into the parallel register-bank transactions consumed by the hash register bank: address, data_in, write_strobe and read_strobe.
- Returns read data on MISO.
- Compares each frame's 7-bit device address against the programmed SPI address, so several ASICs can share one bus.
- Runs entirely in the iCLK domain; SCLK, CS_N and MOSI are oversampled.

Parameters:
- DATA_WIDTH, 8: register data width; equals the SPI byte size.
- ADDR_WIDTH, 8: register address width.
- SYNC_STAGES, 2: synchronizer flops on SCLK, CS_N and MOSI (minimum 2).

Ports:
- iCLK  input  1  system clock; all logic runs on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- SCLK  input  1  SPI clock, asynchronous to iCLK; frequency ≤ iCLK/8.
- CS_N  input  1  SPI chip select, active low.
- MOSI  input  1  SPI data in.
- MISO  output  1  SPI data out.
- MISO_OE  output  1  pad output enable for MISO.
- DEV_ADDR  input  7  this device's SPI address.
- address  output  ADDR_WIDTH  register address.
- data_in  output  DATA_WIDTH  register write data.
- write_strobe  output  1  one-cycle write pulse.
- read_strobe  output  1  one-cycle read pulse.
- data_out  input  DATA_WIDTH  register read data; valid one cycle after read_strobe.
- busy  output  1  high while a frame addressed to this device is in progress.

Behaviour:
- Reset: all outputs 0, state IDLE, bit counter 0.
- Edge detection: SCLK, CS_N and MOSI pass through SYNC_STAGES flops.
  - Rising edge of synchronized SCLK: sample MOSI, shift it in MSB first.
  - Falling edge of synchronized SCLK: shift MISO.
- Frame format:
  - byte0 = {RW, DEV[6:0]}, where RW=1 means read.
  - byte1 = register address.
  - byte2 onward = data bytes.
- FSM states:
  - IDLE → CMD when CS_N falls.
  - CMD, after 8 bits: → ADDR if DEV == DEV_ADDR; otherwise → IGNORE.
  - ADDR, after 8 bits: load address. If RW=0, → WDATA. If RW=1, pulse read_strobe on the next cycle, then → RDATA.
  - WDATA, after each byte:
    - Drive data_in with the byte.
    - Pulse write_strobe for one cycle with the current address.
    - Increment address on the cycle after the strobe.
  - RDATA:
    - Capture data_out into the TX shift register on the cycle after read_strobe.
    - At the end of each byte, increment address and pulse read_strobe again as a prefetch for the next byte.
  - IGNORE: stay here until CS_N rises; no strobes; MISO_OE=0.
- CS_N rising in any state → IDLE on the next cycle.
  - Any partial byte is discarded; no strobe is issued for it.
  - An already-issued strobe is not retracted.
- busy: 1 in ADDR, WDATA and RDATA, and in CMD once the match is known; 0 otherwise.
- MISO / MISO_OE:
  - MISO_OE=1 only in RDATA while CS_N is low.
  - MISO presents the TX MSB within 3 iCLK cycles of capture, i.e. before the first SCLK rise of the byte.
  - MISO shifts on each SCLK fall.
  - MISO=0 whenever MISO_OE=0.
  - During CMD and ADDR, MISO=0 and MISO_OE=0.
- Address increment wraps modulo 2^ADDR_WIDTH (0xFF → 0x00).
- address and data_in hold their values between strobes and are never changed on the same cycle as a strobe.
- write_strobe and read_strobe are never high together; each is high for exactly one iCLK cycle.
- The trailing prefetch read issued at frame end is accepted behaviour (register reads have no side effects).
- Reset asserted mid-frame: everything returns immediately to reset values. After reset releases, nothing happens until the next CS_N fall; a frame already in progress is ignored until CS_N goes high and low again.

Test Plan:
- Write frame with DEV_ADDR=0x15: CS_N low, bytes 0x15, 0x03, 0x2D → one write_strobe with address=0x03, data_in=0x2D; busy=1 during the frame; MISO_OE=0 throughout.
- Burst read: bank model returns 0x11 at address 0x05 and 0x40 at 0x06; frame 0x95, 0x05, 0x00, 0x00 → read_strobe at 0x05, then 0x06, then 0x07 (prefetch); MISO bytes are 0x11 then 0x40.
- Mismatch: DEV_ADDR=0x15, frame 0x16, 0x00, 0xFF → no strobes; busy=0; MISO_OE=0; the next frame 0x15, 0x00, 0xAA writes 0xAA to address 0x00.
- Wrap: write burst 0x15, 0xFF, 0x01, 0x02 → writes 0x01 at address 0xFF, then 0x02 at 0x00.
- Abort: CS_N rises after 5 bits of the first data byte in a write → no write_strobe; state returns to IDLE; the following complete frame executes normally.
- Reset: RST_N pulsed low mid-RDATA → MISO, MISO_OE, strobes and busy go to 0 at once; a clean frame sent after CS_N toggles works.

Source files
------------

// File: rtl/spi_reg_initiator.sv
// SPI mode-0 slave that turns framed serial traffic into register-bank read/write strobes.
// SCLK, CS_N and MOSI are oversampled in the iCLK domain; all outputs are registered.
module spi_reg_initiator #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  iCLK,
   input  logic                  RST_N,
   input  logic                  SCLK,
   input  logic                  CS_N,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic                  MISO_OE,
   input  logic [6:0]            DEV_ADDR,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic                  write_strobe,
   output logic                  read_strobe,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  busy
);

   localparam int unsigned       CntW    = $clog2(DATA_WIDTH);
   localparam logic [CntW-1:0]   LastBit = CntW'(DATA_WIDTH - 1);
   localparam logic [CntW-1:0]   CntOne  = CntW'(1);
   localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StWdata,
      StRdata,
      StIgnore
   } state_e;

   // Synchronizers reset low so a CS_N already low at reset release never looks like a fall.
   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sclk_prev_q, cs_prev_q;

   always_ff @(posedge iCLK or negedge RST_N) begin
      if (!RST_N) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_N};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
         cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      end
   end

   state_e                state_q;
   logic [CntW-1:0]       bit_cnt_q;
   logic [DATA_WIDTH-2:0] rx_q;
   logic [DATA_WIDTH-2:0] tx_q;
   logic                  rw_q;
   logic [ADDR_WIDTH-1:0] address_q;
   logic [DATA_WIDTH-1:0] data_in_q;
   logic                  wstb_q, rstb_q;
   logic                  wr_pend_q, rd_pend_q, cap_pend_q;
   logic                  miso_q, miso_oe_q, busy_q;

   logic                  sclk_s, cs_s, mosi_s;
   logic                  sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic                  active, byte_done, dev_match;
   logic [DATA_WIDTH-1:0] rx_next;

   always_comb begin
      sclk_s    = sclk_sync_q[SYNC_STAGES-1];
      cs_s      = cs_sync_q[SYNC_STAGES-1];
      mosi_s    = mosi_sync_q[SYNC_STAGES-1];
      sclk_rise = sclk_s & ~sclk_prev_q;
      sclk_fall = ~sclk_s & sclk_prev_q;
      cs_fall   = cs_prev_q & ~cs_s;
      cs_rise   = ~cs_prev_q & cs_s;
      active    = (state_q == StCmd) || (state_q == StAddr) ||
                  (state_q == StWdata) || (state_q == StRdata);
      rx_next   = {rx_q, mosi_s};
      byte_done = active && sclk_rise && (bit_cnt_q == LastBit);
      dev_match = (rx_next[6:0] == DEV_ADDR);
   end

   always_ff @(posedge iCLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         rx_q       <= '0;
         tx_q       <= '0;
         rw_q       <= 1'b0;
         address_q  <= '0;
         data_in_q  <= '0;
         wstb_q     <= 1'b0;
         rstb_q     <= 1'b0;
         wr_pend_q  <= 1'b0;
         rd_pend_q  <= 1'b0;
         cap_pend_q <= 1'b0;
         miso_q     <= 1'b0;
         miso_oe_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         // Strobes fire one cycle after the byte completes so address/data_in are already stable.
         wstb_q     <= wr_pend_q;
         rstb_q     <= rd_pend_q;
         wr_pend_q  <= 1'b0;
         rd_pend_q  <= 1'b0;
         cap_pend_q <= rstb_q;

         if (wstb_q) begin
            address_q <= address_q + AddrOne;
         end

         if (active && sclk_rise) begin
            rx_q      <= rx_next[DATA_WIDTH-2:0];
            bit_cnt_q <= (bit_cnt_q == LastBit) ? '0 : bit_cnt_q + CntOne;
         end

         // The fall that closes the previous byte (bit_cnt_q == 0) must not shift the new MSB out.
         if (state_q == StRdata) begin
            if (cap_pend_q) begin
               miso_q <= data_out[DATA_WIDTH-1];
               tx_q   <= data_out[DATA_WIDTH-2:0];
            end else if (sclk_fall && (bit_cnt_q != '0)) begin
               miso_q <= tx_q[DATA_WIDTH-2];
               tx_q   <= {tx_q[DATA_WIDTH-3:0], 1'b0};
            end
         end

         case (state_q)
            StIdle: begin
               if (cs_fall) begin
                  state_q   <= StCmd;
                  bit_cnt_q <= '0;
               end
            end
            StCmd: begin
               if (byte_done) begin
                  rw_q    <= rx_next[DATA_WIDTH-1];
                  busy_q  <= dev_match;
                  state_q <= dev_match ? StAddr : StIgnore;
               end
            end
            StAddr: begin
               if (byte_done) begin
                  address_q <= ADDR_WIDTH'(rx_next);
                  if (rw_q) begin
                     rd_pend_q <= 1'b1;
                     miso_oe_q <= 1'b1;
                     state_q   <= StRdata;
                  end else begin
                     state_q   <= StWdata;
                  end
               end
            end
            StWdata: begin
               if (byte_done) begin
                  data_in_q <= rx_next;
                  wr_pend_q <= 1'b1;
               end
            end
            StRdata: begin
               if (byte_done) begin
                  address_q <= address_q + AddrOne;
                  rd_pend_q <= 1'b1;
               end
            end
            StIgnore: begin
            end
            default: begin
               state_q <= StIdle;
            end
         endcase

         // Deselect wins over everything above; a partial byte simply evaporates.
         if (cs_rise) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
         end
      end
   end

   assign MISO         = miso_q;
   assign MISO_OE      = miso_oe_q;
   assign address      = address_q;
   assign data_in      = data_in_q;
   assign write_strobe = wstb_q;
   assign read_strobe  = rstb_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_spi_reg_initiator.sv
// Bench for spi_reg_initiator: drives SPI frames, models the register bank and scoreboards
// every strobe plus the returned MISO bytes against expectations built from stimulus.
`timescale 1ns/1ps
module tb_spi_reg_initiator;

   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       cs_n = 1'b1;
   logic       mosi = 1'b0;
   logic [6:0] dev_addr = 7'h15;
   logic       miso, miso_oe, wstb, rstb, busy;
   logic [7:0] address, data_in;
   logic [7:0] data_out = 8'h00;
   logic [7:0] mem [256];

   typedef struct packed {
      logic       wr;
      logic [7:0] a;
      logic [7:0] d;
   } ev_t;

   ev_t  exp_q[$];
   ev_t  obs_q[$];
   ev_t  e, o;
   int   n_tests = 0;
   int   n_fail = 0;
   int   proto_err = 0;
   logic seen_busy = 1'b0;
   logic seen_oe = 1'b0;
   logic seen_bad_miso = 1'b0;
   logic prev_stb = 1'b0;
   logic [7:0] prev_addr = 8'h00;
   logic [7:0] prev_din = 8'h00;
   logic [7:0] fb [4];
   logic [7:0] rb [4];

   spi_reg_initiator #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (8),
      .SYNC_STAGES(2)
   ) dut (
      .iCLK        (clk),
      .RST_N       (rst_n),
      .SCLK        (sclk),
      .CS_N        (cs_n),
      .MOSI        (mosi),
      .MISO        (miso),
      .MISO_OE     (miso_oe),
      .DEV_ADDR    (dev_addr),
      .address     (address),
      .data_in     (data_in),
      .write_strobe(wstb),
      .read_strobe (rstb),
      .data_out    (data_out),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Register bank: read data valid the cycle after read_strobe.
   always @(posedge clk) begin
      if (wstb) mem[address] <= data_in;
      if (rstb) data_out <= mem[address];
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (wstb) obs_q.push_back('{wr: 1'b1, a: address, d: data_in});
         if (rstb) obs_q.push_back('{wr: 1'b0, a: address, d: 8'h00});
         if (wstb && rstb) proto_err++;
         if ((wstb || rstb) && prev_stb) proto_err++;
         if ((wstb || rstb) && ((address !== prev_addr) || (data_in !== prev_din))) proto_err++;
         if (busy) seen_busy = 1'b1;
         if (miso_oe) seen_oe = 1'b1;
         if (miso && !miso_oe) seen_bad_miso = 1'b1;
         prev_stb  = wstb | rstb;
         prev_addr = address;
         prev_din  = data_in;
      end
   end

   task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = tx[i];
         repeat (HALF) @(negedge clk);
         rx[i] = miso;
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic send_frame(input int n);
      seen_busy = 1'b0;
      seen_oe = 1'b0;
      seen_bad_miso = 1'b0;
      cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int k = 0; k < n; k++) spi_xfer(fb[k], 8, rb[k]);
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      repeat (4 * HALF) @(negedge clk);
   endtask

   task automatic push_exp(input logic wr, input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back('{wr: wr, a: a, d: d});
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({miso, miso_oe, wstb, rstb, busy} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got miso/oe/wr/rd/busy=%b, expected 00000",
                  {miso, miso_oe, wstb, rstb, busy});
      end
      n_tests++;
      if ({address, data_in} !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_bus: got addr=%h din=%h, expected 00 00", address, data_in);
      end
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_busy: got %b, expected 0", busy);
      end
   endtask

   task automatic test_write;
      fb = '{8'h15, 8'h03, 8'h2D, 8'h00};
      push_exp(1'b1, 8'h03, 8'h2D);
      send_frame(3);
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL write_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL write_event: got wr=%b a=%h d=%h, expected wr=%b a=%h d=%h",
                     o.wr, o.a, o.d, e.wr, e.a, e.d);
         end
      end
      exp_q.delete();
      obs_q.delete();
      n_tests++;
      if ({seen_busy, seen_oe, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL write_busy_oe: got seen_busy/seen_oe/busy_after=%b, expected 100",
                  {seen_busy, seen_oe, busy});
      end
   endtask

   task automatic test_burst_read;
      mem[8'h05] = 8'h11;
      mem[8'h06] = 8'h40;
      mem[8'h07] = 8'hE7;
      fb = '{8'h95, 8'h05, 8'h00, 8'h00};
      push_exp(1'b0, 8'h05, 8'h00);
      push_exp(1'b0, 8'h06, 8'h00);
      push_exp(1'b0, 8'h07, 8'h00);
      send_frame(4);
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL read_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL read_event: got wr=%b a=%h, expected wr=%b a=%h", o.wr, o.a, e.wr, e.a);
         end
      end
      exp_q.delete();
      obs_q.delete();
      n_tests++;
      if ({rb[2], rb[3]} !== 16'h1140) begin
         n_fail++;
         $display("FAIL read_miso: got %h %h, expected 11 40", rb[2], rb[3]);
      end
      n_tests++;
      if ({seen_oe, seen_bad_miso, miso_oe, miso} !== 4'b1000) begin
         n_fail++;
         $display("FAIL read_oe: got seen_oe/bad_miso/oe_after/miso_after=%b, expected 1000",
                  {seen_oe, seen_bad_miso, miso_oe, miso});
      end
   endtask

   task automatic test_mismatch;
      fb = '{8'h16, 8'h00, 8'hFF, 8'h00};
      send_frame(3);
      n_tests++;
      if ({obs_q.size() != 0, seen_busy, seen_oe} !== 3'b000) begin
         n_fail++;
         $display("FAIL mismatch_quiet: got strobes=%0d busy=%b oe=%b, expected 0 0 0",
                  obs_q.size(), seen_busy, seen_oe);
      end
      obs_q.delete();
      fb = '{8'h15, 8'h00, 8'hAA, 8'h00};
      push_exp(1'b1, 8'h00, 8'hAA);
      send_frame(3);
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL mismatch_next_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL mismatch_next_event: got wr=%b a=%h d=%h, expected wr=%b a=%h d=%h",
                     o.wr, o.a, o.d, e.wr, e.a, e.d);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_wrap;
      fb = '{8'h15, 8'hFF, 8'h01, 8'h02};
      push_exp(1'b1, 8'hFF, 8'h01);
      push_exp(1'b1, 8'h00, 8'h02);
      send_frame(4);
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL wrap_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL wrap_event: got wr=%b a=%h d=%h, expected wr=%b a=%h d=%h",
                     o.wr, o.a, o.d, e.wr, e.a, e.d);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_abort;
      logic [7:0] dummy;
      cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_xfer(8'h15, 8, dummy);
      spi_xfer(8'h20, 8, dummy);
      spi_xfer(8'h77, 5, dummy);
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      repeat (4 * HALF) @(negedge clk);
      n_tests++;
      if ({obs_q.size() != 0, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL abort_quiet: got strobes=%0d busy=%b, expected 0 0", obs_q.size(), busy);
      end
      obs_q.delete();
      fb = '{8'h15, 8'h21, 8'h5A, 8'h00};
      push_exp(1'b1, 8'h21, 8'h5A);
      send_frame(3);
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL abort_next_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL abort_next_event: got wr=%b a=%h d=%h, expected wr=%b a=%h d=%h",
                     o.wr, o.a, o.d, e.wr, e.a, e.d);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset_mid;
      logic [7:0] dummy;
      mem[8'h30] = 8'hFF;
      cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_xfer(8'h95, 8, dummy);
      spi_xfer(8'h30, 8, dummy);
      spi_xfer(8'h00, 3, dummy);
      repeat (2) @(negedge clk);
      n_tests++;
      if ({miso_oe, miso, busy} !== 3'b111) begin
         n_fail++;
         $display("FAIL rstmid_pre: got oe/miso/busy=%b, expected 111", {miso_oe, miso, busy});
      end
      n_tests++;
      if ((obs_q.size() != 1) || (obs_q[0] !== ev_t'({1'b0, 8'h30, 8'h00}))) begin
         n_fail++;
         $display("FAIL rstmid_read: got %0d strobes, expected one read at 30", obs_q.size());
      end
      obs_q.delete();
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({miso, miso_oe, wstb, rstb, busy} !== 5'b0) begin
         n_fail++;
         $display("FAIL rstmid_async: got miso/oe/wr/rd/busy=%b, expected 00000",
                  {miso, miso_oe, wstb, rstb, busy});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      seen_busy = 1'b0;
      seen_oe = 1'b0;
      spi_xfer(8'h15, 8, dummy);
      spi_xfer(8'hA5, 8, dummy);
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      repeat (4 * HALF) @(negedge clk);
      n_tests++;
      if ({obs_q.size() != 0, seen_busy, seen_oe} !== 3'b000) begin
         n_fail++;
         $display("FAIL rstmid_ignored: got strobes=%0d busy=%b oe=%b, expected 0 0 0",
                  obs_q.size(), seen_busy, seen_oe);
      end
      obs_q.delete();
      fb = '{8'h15, 8'h40, 8'h99, 8'h00};
      push_exp(1'b1, 8'h40, 8'h99);
      send_frame(3);
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL rstmid_next_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL rstmid_next_event: got wr=%b a=%h d=%h, expected wr=%b a=%h d=%h",
                     o.wr, o.a, o.d, e.wr, e.a, e.d);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_protocol;
      n_tests++;
      if ((proto_err != 0) || seen_bad_miso) begin
         n_fail++;
         $display("FAIL protocol: got %0d strobe violations, bad_miso=%b, expected 0 0",
                  proto_err, seen_bad_miso);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      test_reset();
      test_write();
      test_burst_read();
      test_mismatch();
      test_wrap();
      test_abort();
      test_reset_mid();
      test_protocol();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
